// File: rtl/cmd_frame_parser_pkg.sv
// Shared encodings for the comm-port command parser: FSM states, command codes,
// header defaults and small frame helpers.
package cmd_frame_parser_pkg;

  localparam logic [2:0] S_H0   = 3'd0;
  localparam logic [2:0] S_H1   = 3'd1;
  localparam logic [2:0] S_CMD  = 3'd2;
  localparam logic [2:0] S_ARG  = 3'd3;
  localparam logic [2:0] S_SUM  = 3'd4;
  localparam logic [2:0] S_EXEC = 3'd5;
  localparam logic [2:0] S_ACK  = 3'd6;

  localparam logic [7:0] CMD_SW_A  = 8'h01;
  localparam logic [7:0] CMD_SW_B  = 8'h02;
  localparam logic [7:0] CMD_RST_A = 8'h03;
  localparam logic [7:0] CMD_RST_B = 8'h04;
  localparam logic [7:0] CMD_FWD   = 8'h10;

  localparam logic [7:0] HDR0_DEF = 8'hEB;
  localparam logic [7:0] HDR1_DEF = 8'h90;

  function automatic logic cmd_known(input logic [7:0] c);
    case (c)
      CMD_SW_A, CMD_SW_B, CMD_RST_A, CMD_RST_B, CMD_FWD: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] frame_sum(input logic [7:0] cmd, input logic [7:0] arg);
    return cmd + arg;
  endfunction

endpackage

// File: rtl/cmd_frame_parser_pulse_stretch.sv
// Purpose: load/restart down-counter giving a level N cycles wide.
// Latency: level rises the cycle after load; load while active restarts the count.
// Backpressure: none.
module cmd_frame_parser_pulse_stretch #(
  parameter int N = 1000,
  parameter int W = $clog2(N + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic pulse
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(N);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign pulse = (cnt != '0);

endmodule

// File: rtl/cmd_frame_parser.sv
// Purpose: pops comm FIFO bytes, parses EB 90 CMD ARG SUM frames, drives switch/reset/forward outputs.
// Latency: actions appear 2 clocks after the SUM pop; at most one pop per 2 clocks.
// Backpressure: pops only when com_count != 0; fetch blocked during EXEC (and ACK with CMD_ACK_EN).
module cmd_frame_parser
  import cmd_frame_parser_pkg::*;
#(
  parameter int         CW             = 5,
  parameter logic [7:0] HDR0           = HDR0_DEF,
  parameter logic [7:0] HDR1           = HDR1_DEF,
  parameter int         TIMEOUT_CYCLES = 200000,
  parameter int         RST_CYCLES     = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rec_command,
  input  logic [CW-1:0] com_count,
  output logic          com_pop,
  output logic          force_swi,
  output logic          com_swi,
  output logic          reset_A,
  output logic          reset_B,
  output logic          error,
  output logic [7:0]    tdr_cpuAB,
  output logic          tf_push_cpuAB
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    state;
  logic          gap;
  logic [7:0]    byte_q;
  logic [7:0]    cmd_q;
  logic [7:0]    arg_q;
  logic [TW-1:0] tmo_cnt;
`ifdef CMD_ACK_EN
  logic          ok_q;
  logic [1:0]    ack_idx;
`endif

  logic fetch_state, tmo_active, tmo_hit, exec_now, frame_good, load_a, load_b;

  // The byte popped in one cycle is decoded in the following gap cycle.
  assign fetch_state = (state == S_H0) || (state == S_H1) || (state == S_CMD) ||
                       (state == S_ARG) || (state == S_SUM);
  assign com_pop     = !rst && fetch_state && !gap && (com_count != '0);
  assign tmo_active  = (state == S_H1) || (state == S_CMD) || (state == S_ARG) || (state == S_SUM);
  assign tmo_hit     = tmo_active && !gap && !com_pop && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign exec_now    = (state == S_SUM) && gap;
  assign frame_good  = (byte_q == frame_sum(cmd_q, arg_q)) && cmd_known(cmd_q);
  assign load_a      = exec_now && frame_good && (cmd_q == CMD_RST_A);
  assign load_b      = exec_now && frame_good && (cmd_q == CMD_RST_B);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_H0;
      gap           <= 1'b0;
      byte_q        <= '0;
      cmd_q         <= '0;
      arg_q         <= '0;
      tmo_cnt       <= '0;
      force_swi     <= 1'b0;
      com_swi       <= 1'b0;
      error         <= 1'b0;
      tdr_cpuAB     <= '0;
      tf_push_cpuAB <= 1'b0;
`ifdef CMD_ACK_EN
      ok_q          <= 1'b0;
      ack_idx       <= '0;
`endif
    end else begin
      force_swi     <= 1'b0;
      tf_push_cpuAB <= 1'b0;
      gap           <= com_pop;
      if (com_pop) byte_q <= rec_command;
      tmo_cnt <= (com_pop || !tmo_active) ? '0 : tmo_cnt + 1'b1;

      if (tmo_hit) begin
        state <= S_H0;
        error <= 1'b1;
      end else begin
        case (state)
          S_H0: if (gap && byte_q == HDR0) state <= S_H1;
          S_H1: if (gap) begin
            if (byte_q == HDR1)      state <= S_CMD;
            else if (byte_q != HDR0) state <= S_H0;
          end
          S_CMD: if (gap) begin
            cmd_q <= byte_q;
            state <= S_ARG;
          end
          S_ARG: if (gap) begin
            arg_q <= byte_q;
            state <= S_SUM;
          end
          S_SUM: if (gap) begin
            state <= S_EXEC;
            error <= !frame_good;
`ifdef CMD_ACK_EN
            ok_q  <= frame_good;
`endif
            if (frame_good) begin
              case (cmd_q)
                CMD_SW_A: begin com_swi <= 1'b0; force_swi <= 1'b1; end
                CMD_SW_B: begin com_swi <= 1'b1; force_swi <= 1'b1; end
                CMD_FWD:  begin tdr_cpuAB <= arg_q; tf_push_cpuAB <= 1'b1; end
                default: ;
              endcase
            end
          end
`ifdef CMD_ACK_EN
          S_EXEC: begin
            if (ok_q) begin
              state         <= S_ACK;
              ack_idx       <= 2'd0;
              tdr_cpuAB     <= HDR0;
              tf_push_cpuAB <= 1'b1;
            end else begin
              state <= S_H0;
            end
          end
          // Acknowledge bytes HDR0, HDR1, CMD leave on consecutive cycles.
          S_ACK: begin
            case (ack_idx)
              2'd0: begin tdr_cpuAB <= HDR1;  tf_push_cpuAB <= 1'b1; ack_idx <= 2'd1; end
              2'd1: begin tdr_cpuAB <= cmd_q; tf_push_cpuAB <= 1'b1; ack_idx <= 2'd2; end
              default: state <= S_H0;
            endcase
          end
`else
          S_EXEC: state <= S_H0;
`endif
          default: state <= S_H0;
        endcase
      end
    end
  end

  cmd_frame_parser_pulse_stretch #(.N(RST_CYCLES)) u_rst_a (
    .clk   (clk),
    .rst   (rst),
    .load  (load_a),
    .pulse (reset_A)
  );

  cmd_frame_parser_pulse_stretch #(.N(RST_CYCLES)) u_rst_b (
    .clk   (clk),
    .rst   (rst),
    .load  (load_b),
    .pulse (reset_B)
  );

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Directed bench for cmd_frame_parser: frame vector table plus multi-cycle sequences.
module tb_cmd_frame_parser;

  localparam int CW   = 5;
  localparam int TMO  = 3000;
  localparam int RSTC = 1000;
`ifdef CMD_ACK_EN
  localparam int ACK_PUSHES = 3;
`else
  localparam int ACK_PUSHES = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rec_command;
  logic [CW-1:0] com_count;
  logic          com_pop, force_swi, com_swi, reset_A, reset_B, error, tf_push_cpuAB;
  logic [7:0]    tdr_cpuAB;

  cmd_frame_parser #(.CW(CW), .TIMEOUT_CYCLES(TMO), .RST_CYCLES(RSTC)) dut (
    .clk           (clk),
    .rst           (rst),
    .rec_command   (rec_command),
    .com_count     (com_count),
    .com_pop       (com_pop),
    .force_swi     (force_swi),
    .com_swi       (com_swi),
    .reset_A       (reset_A),
    .reset_B       (reset_B),
    .error         (error),
    .tdr_cpuAB     (tdr_cpuAB),
    .tf_push_cpuAB (tf_push_cpuAB)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] b;
    int          n;
    logic        exp_swi;
    logic        exp_err;
    int          exp_force;
    int          exp_fwd;
    logic [7:0]  exp_tdr;
    logic        valid;
  } vec_t;

  logic [7:0] fifo[$];
  int         pop_cyc[$];
  logic [7:0] push_dat[$];
  int         push_cyc[$];
  int n_cmp = 0, n_fail = 0;
  int cyc = 0, pops = 0, last_pop = 0, dbl_pop = 0;
  int force_n = 0, last_force = 0;
  int ra_n = 0, ra_first = 0, ra_last = 0, rb_n = 0;
  logic prev_pop = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample outputs mid-cycle, then model the FIFO head after the edge.
  task automatic tick();
    logic pop_s;
    @(negedge clk);
    cyc++;
    pop_s = com_pop;
    if (pop_s) begin
      pops++;
      last_pop = cyc;
      pop_cyc.push_back(cyc);
      if (prev_pop) dbl_pop++;
    end
    prev_pop = pop_s;
    if (force_swi) begin force_n++; last_force = cyc; end
    if (tf_push_cpuAB) begin push_dat.push_back(tdr_cpuAB); push_cyc.push_back(cyc); end
    if (reset_A) begin
      if (ra_n == 0) ra_first = cyc;
      ra_n++;
      ra_last = cyc;
    end
    if (reset_B) rb_n++;
    @(posedge clk);
    #1;
    if (pop_s && fifo.size() > 0) fifo.delete(0);
    com_count   = CW'(fifo.size());
    rec_command = (fifo.size() > 0) ? fifo[0] : 8'h00;
  endtask

  task automatic push_bytes(input logic [63:0] b, input int n);
    for (int i = 0; i < n; i++) fifo.push_back(b[63 - 8*i -: 8]);
  endtask

  task automatic clear_stats();
    pops = 0; force_n = 0; ra_n = 0; rb_n = 0;
    pop_cyc.delete(); push_dat.delete(); push_cyc.delete();
  endtask

  function automatic vec_t mk(input logic [63:0] b, input int n, input logic swi, input logic err,
                              input int frc, input int fwd, input logic [7:0] tdr, input logic valid);
    vec_t v;
    v.b = b; v.n = n; v.exp_swi = swi; v.exp_err = err;
    v.exp_force = frc; v.exp_fwd = fwd; v.exp_tdr = tdr; v.valid = valid;
    return v;
  endfunction

  vec_t vecs[9];
  int p, exp_push;

  initial begin
    vecs[0] = mk(64'hEB90020002000000, 5, 1'b1, 1'b0, 1, 0, 8'h00, 1'b1);
    vecs[1] = mk(64'hEB90105A6A000000, 5, 1'b1, 1'b0, 0, 1, 8'h5A, 1'b1);
    vecs[2] = mk(64'hEB90010007000000, 5, 1'b1, 1'b1, 0, 0, 8'h00, 1'b0);
    vecs[3] = mk(64'hEB90010001000000, 5, 1'b0, 1'b0, 1, 0, 8'h00, 1'b1);
    vecs[4] = mk(64'hEB90050005000000, 5, 1'b0, 1'b1, 0, 0, 8'h00, 1'b0);
    vecs[5] = mk(64'hEB9010FF0F000000, 5, 1'b0, 1'b0, 0, 1, 8'hFF, 1'b1);
    vecs[6] = mk(64'hEB9002FF01000000, 5, 1'b1, 1'b0, 1, 0, 8'h00, 1'b1);
    vecs[7] = mk(64'h33EBEB9001000100, 7, 1'b0, 1'b0, 1, 0, 8'h00, 1'b1);
    vecs[8] = mk(64'h90EB12EB90020002, 8, 1'b1, 1'b0, 1, 0, 8'h00, 1'b1);

    rst = 1'b1;
    com_count = '0;
    rec_command = 8'h00;
    repeat (3) tick();
    chk("rst com_pop", com_pop, 0);
    chk("rst force_swi", force_swi, 0);
    chk("rst com_swi", com_swi, 0);
    chk("rst reset_A", reset_A, 0);
    chk("rst reset_B", reset_B, 0);
    chk("rst error", error, 0);
    chk("rst tdr", tdr_cpuAB, 0);
    chk("rst tf_push", tf_push_cpuAB, 0);
    rst = 1'b0;
    repeat (2) tick();

    for (int v = 0; v < 9; v++) begin
      clear_stats();
      push_bytes(vecs[v].b, vecs[v].n);
      repeat (vecs[v].n * 2 + 12) tick();
      chk($sformatf("v%0d pops", v), pops, vecs[v].n);
      chk($sformatf("v%0d com_swi", v), com_swi, vecs[v].exp_swi);
      chk($sformatf("v%0d error", v), error, vecs[v].exp_err);
      chk($sformatf("v%0d force count", v), force_n, vecs[v].exp_force);
      if (vecs[v].exp_force > 0) chk($sformatf("v%0d force latency", v), last_force - last_pop, 2);
      exp_push = vecs[v].exp_fwd + (vecs[v].valid ? ACK_PUSHES : 0);
      chk($sformatf("v%0d push count", v), push_dat.size(), exp_push);
      if (vecs[v].exp_fwd > 0 && push_dat.size() > 0) begin
        chk($sformatf("v%0d tdr", v), push_dat[0], vecs[v].exp_tdr);
        chk($sformatf("v%0d push latency", v), push_cyc[0] - last_pop, 2);
      end
    end

    // reset_A pulse, restart at mid-pulse, overlapping reset_B pulse
    clear_stats();
    push_bytes(64'h33EBEB9003000300, 7);
    repeat (20) tick();
    chk("rstA rise latency", ra_first - last_pop, 2);
    chk("rstA error", error, 0);
    p = ra_first;
    while (cyc < p + 500) tick();
    pop_cyc.delete();
    push_bytes(64'hEB90030003000000, 5);
    push_bytes(64'hEB90040004000000, 5);
    repeat (1200) tick();
    chk("restart pops", pop_cyc.size(), 10);
    if (pop_cyc.size() == 10) begin
      chk("rstA end after restart", ra_last, pop_cyc[4] + 2 + RSTC - 1);
      chk("rstB rise with A active", (pop_cyc[9] + 2 > ra_first) && (pop_cyc[9] + 2 <= ra_last), 1);
    end
    chk("rstA contiguous", ra_n, ra_last - ra_first + 1);
    chk("rstB width", rb_n, RSTC);

    // inter-byte timeout mid-frame
    clear_stats();
    push_bytes(64'hEB90040000000000, 3);
    repeat (10) tick();
    p = last_pop;
    while (cyc < p + TMO - 2) tick();
    chk("tmo early error", error, 0);
    while (cyc < p + TMO + 3) tick();
    chk("tmo error", error, 1);
    chk("tmo reset_B", rb_n, 0);
    push_bytes(64'hEB90010001000000, 5);
    repeat (30) tick();
    chk("after tmo error", error, 0);
    chk("after tmo force", force_n, 1);

    // synchronous reset mid-pulse and mid-frame
    push_bytes(64'hEB90020002000000, 5);
    push_bytes(64'hEB90030003000000, 5);
    push_bytes(64'hEB90020000000000, 3);
    repeat (40) tick();
    chk("pre-rst com_swi", com_swi, 1);
    chk("pre-rst reset_A", reset_A, 1);
    rst = 1'b1;
    tick();
    chk("mid rst com_swi", com_swi, 0);
    chk("mid rst reset_A", reset_A, 0);
    chk("mid rst com_pop", com_pop, 0);
    chk("mid rst error", error, 0);
    rst = 1'b0;
    clear_stats();
    push_bytes(64'h0001EB9002000200, 7);
    repeat (40) tick();
    chk("post rst force", force_n, 1);
    chk("post rst com_swi", com_swi, 1);
    chk("post rst reset_A", ra_n, 0);

`ifdef CMD_ACK_EN
    clear_stats();
    push_bytes(64'hEB90104151000000, 5);
    repeat (30) tick();
    chk("ack push count", push_dat.size(), 4);
    if (push_dat.size() == 4) begin
      chk("ack b0", push_dat[0], 8'h41);
      chk("ack b1", push_dat[1], 8'hEB);
      chk("ack b2", push_dat[2], 8'h90);
      chk("ack b3", push_dat[3], 8'h10);
      chk("ack consecutive", push_cyc[3] - push_cyc[0], 3);
      chk("ack no pop", last_pop < push_cyc[0], 1);
    end
`endif

    chk("no back-to-back pops", dbl_pop, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
